alu_issue_ctrl: RTL and testbench

//  Front-end controller that drives the registered 16-bit ALU. Accepts one instruction at a time

---
 rtl/alu_issue_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the registered 16-bit ALU: accept, issue, capture, writeback/branch.
// Optional performance counters are enabled by defining ALU_ISSUE_PERF_EN.
module alu_issue_ctrl #(
  parameter int DW = 16,
  parameter int RW = 3
`ifdef ALU_ISSUE_PERF_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [15:0]   instr,
  output logic [RW-1:0] rf_a_addr,
  output logic [RW-1:0] rf_b_addr,
  input  logic [DW-1:0] rf_a_data,
  input  logic [DW-1:0] rf_b_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_op,
  output logic          alu_c1,
  output logic          alu_z,
  input  logic [DW-1:0] alu_res,
  input  logic          alu_carry,
  input  logic          alu_zero,
  output logic          wb_valid,
  output logic [RW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  output logic          br_valid,
  output logic          br_taken,
  output logic          flag_c,
  output logic          flag_z
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_retired,
  output logic [CNT_W-1:0] perf_skipped
`endif
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;

  localparam logic [3:0] OPC_ADD  = 4'b0001;
  localparam logic [3:0] OPC_NAND = 4'b0010;
  localparam logic [3:0] OPC_LLI  = 4'b0011;
  localparam logic [3:0] OPC_BEQ  = 4'b1000;
  localparam logic [3:0] OPC_BLT  = 4'b1001;
  localparam logic [3:0] OPC_BLE  = 4'b1010;

  logic [1:0]    state_q, state_d;
  logic [15:0]   instr_q, instr_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic          flag_c_q, flag_c_d;
  logic          flag_z_q, flag_z_d;

  logic [3:0]    opc;
  logic [1:0]    cz;
  logic          cond_ok;
  logic          exec;
  logic          is_branch;
  logic [3:0]    dec_op;
  logic [DW-1:0] dec_b;

  assign opc     = instr_q[15:12];
  assign cz      = instr_q[1:0];
  assign cond_ok = (cz == 2'b10) ? flag_c_q : ((cz == 2'b01) ? flag_z_q : 1'b1);

  // Decode of the latched instruction; exec=0 marks a skip (false condition or illegal opcode).
  always_comb begin
    exec      = 1'b0;
    is_branch = 1'b0;
    dec_op    = 4'b1111;
    dec_b     = b_q;
    case (opc)
      OPC_ADD: begin
        exec   = cond_ok;
        dec_op = {2'b00, instr_q[2], (cz == 2'b11)};
      end
      OPC_NAND: begin
        exec   = cond_ok;
        dec_op = instr_q[2] ? 4'b0101 : 4'b0100;
      end
      OPC_LLI: begin
        exec   = 1'b1;
        dec_op = 4'b1001;
        dec_b  = {{(DW-9){1'b0}}, instr_q[8:0]};
      end
      OPC_BEQ: begin
        exec      = 1'b1;
        is_branch = 1'b1;
        dec_op    = 4'b0110;
      end
      OPC_BLT: begin
        exec      = 1'b1;
        is_branch = 1'b1;
        dec_op    = 4'b0111;
      end
      OPC_BLE: begin
        exec      = 1'b1;
        is_branch = 1'b1;
        dec_op    = 4'b1000;
      end
      default: exec = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    a_d      = a_q;
    b_d      = b_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          state_d = S_ISSUE;
          instr_d = instr;
          a_d     = rf_a_data;
          b_d     = rf_b_data;
        end
      end
      S_ISSUE: state_d = exec ? S_CAPTURE : S_IDLE;
      S_CAPTURE: begin
        state_d = S_IDLE;
        if (opc == OPC_ADD) begin
          flag_c_d = alu_carry;
          flag_z_d = alu_zero;
        end else if (opc == OPC_NAND) begin
          flag_z_d = alu_zero;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
    end
  end

  logic issuing;
  logic capturing;
  assign issuing   = (state_q == S_ISSUE) && exec;
  assign capturing = (state_q == S_CAPTURE);

  assign instr_ready = (state_q == S_IDLE);
  assign rf_a_addr   = instr[11:9];
  assign rf_b_addr   = instr[8:6];

  // Outside an executing ISSUE cycle the ALU sees the idle opcode so its flags pass through.
  assign alu_op = issuing ? dec_op : 4'b1111;
  assign alu_a  = issuing ? a_q    : '0;
  assign alu_b  = issuing ? dec_b  : '0;
  assign alu_c1 = flag_c_q;
  assign alu_z  = flag_z_q;

  assign wb_valid = capturing && !is_branch;
  assign wb_addr  = wb_valid ? ((opc == OPC_LLI) ? instr_q[11:9] : instr_q[5:3]) : '0;
  assign wb_data  = wb_valid ? alu_res : '0;
  assign br_valid = capturing && is_branch;
  assign br_taken = br_valid && alu_res[0];
  assign flag_c   = flag_c_q;
  assign flag_z   = flag_z_q;

`ifdef ALU_ISSUE_PERF_EN
  logic [CNT_W-1:0] retired_q;
  logic [CNT_W-1:0] skipped_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
      skipped_q <= '0;
    end else begin
      if (capturing) retired_q <= retired_q + 1'b1;
      if ((state_q == S_ISSUE) && !exec) skipped_q <= skipped_q + 1'b1;
    end
  end

  assign perf_retired = retired_q;
  assign perf_skipped = skipped_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural registered ALU, register file and instruction-level model.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rstN;
  logic        instrValid;
  logic        instrReady;
  logic [15:0] instr;
  logic [2:0]  rfAAddr, rfBAddr;
  logic [15:0] rfAData, rfBData;
  logic [15:0] aluA, aluB;
  logic [3:0]  aluOp;
  logic        aluC1, aluZ;
  logic [15:0] aluRes;
  logic        aluCarry, aluZero;
  logic        wbValid;
  logic [2:0]  wbAddr;
  logic [15:0] wbData;
  logic        brValid, brTaken;
  logic        flagC, flagZ;

  int total = 0;
  int bad = 0;

  logic [15:0] rf [8];
  logic [15:0] refRf [8];
  logic        refC, refZ;
  logic        pokeEn;
  logic [2:0]  pokeAddr;
  logic [15:0] pokeData;
  logic [3:0]  legalOpc [6];

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rstN), .instr_valid(instrValid), .instr_ready(instrReady), .instr(instr),
    .rf_a_addr(rfAAddr), .rf_b_addr(rfBAddr), .rf_a_data(rfAData), .rf_b_data(rfBData),
    .alu_a(aluA), .alu_b(aluB), .alu_op(aluOp), .alu_c1(aluC1), .alu_z(aluZ),
    .alu_res(aluRes), .alu_carry(aluCarry), .alu_zero(aluZero),
    .wb_valid(wbValid), .wb_addr(wbAddr), .wb_data(wbData),
    .br_valid(brValid), .br_taken(brTaken), .flag_c(flagC), .flag_z(flagZ)
  );

  // Reference ALU behaviour: returns {carry, zero, result}.
  function automatic logic [17:0] aluCompute(input logic [3:0] op, input logic [15:0] a,
                                             input logic [15:0] b, input logic cin, input logic zin);
    int unsigned sum;
    logic [15:0] r;
    logic c, z;
    sum = 0; r = 16'd0; c = cin; z = zin;
    case (op)
      4'd0: sum = int'(a) + int'(b);
      4'd1: sum = int'(a) + int'(b) + int'(cin);
      4'd2: sum = int'(a) + int'(~b);
      4'd3: sum = int'(a) + int'(~b) + int'(cin);
      4'd4: r = ~(a & b);
      4'd5: r = ~(a & ~b);
      4'd6: r = (a == b) ? 16'd1 : 16'd0;
      4'd7: r = (a < b) ? 16'd1 : 16'd0;
      4'd8: r = (a <= b) ? 16'd1 : 16'd0;
      4'd9: r = b;
      default: r = 16'd0;
    endcase
    if (op <= 4'd3) begin
      r = sum[15:0];
      c = sum > 32'hFFFF;
    end
    if (op <= 4'd5) z = (r == 16'd0);
    return {c, z, r};
  endfunction

  always @(posedge clk or negedge rstN) begin
    if (!rstN) {aluCarry, aluZero, aluRes} <= 18'd0;
    else       {aluCarry, aluZero, aluRes} <= aluCompute(aluOp, aluA, aluB, aluC1, aluZ);
  end

  always @(posedge clk) begin
    if (pokeEn)       rf[pokeAddr] <= pokeData;
    else if (wbValid) rf[wbAddr]   <= wbData;
  end

  assign rfAData = rf[rfAAddr];
  assign rfBData = rf[rfBAddr];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pokeReg(input int idx, input logic [15:0] val);
    pokeEn = 1'b1; pokeAddr = 3'(idx); pokeData = val;
    refRf[idx] = val;
    @(posedge clk); #1;
    pokeEn = 1'b0;
  endtask

  // Drives one instruction from IDLE and checks issue, capture and post-capture against the model.
  task automatic applyStimulus(input logic [15:0] w);
    logic [3:0]  opc, op;
    logic [2:0]  ra, rb, rc, dest;
    logic [1:0]  cz;
    logic        run, isBr, c, z;
    logic [15:0] va, vb, expB, res;
    opc = w[15:12]; ra = w[11:9]; rb = w[8:6]; rc = w[5:3]; cz = w[1:0];
    va = refRf[ra]; vb = refRf[rb];
    run = 1'b1; op = 4'hF;
    case (opc)
      4'h1: op = 4'((w[2] ? 2 : 0) + ((cz == 2'b11) ? 1 : 0));
      4'h2: op = w[2] ? 4'h5 : 4'h4;
      4'h3: op = 4'h9;
      4'h8: op = 4'h6;
      4'h9: op = 4'h7;
      4'hA: op = 4'h8;
      default: run = 1'b0;
    endcase
    if ((opc == 4'h1) || (opc == 4'h2))
      run = !((cz == 2'b10 && !refC) || (cz == 2'b01 && !refZ));
    expB = (opc == 4'h3) ? {7'd0, w[8:0]} : vb;
    {c, z, res} = aluCompute(op, va, expB, refC, refZ);
    isBr = (opc >= 4'h8);
    dest = (opc == 4'h3) ? ra : rc;

    instrValid = 1'b1; instr = w;
    #1;
    checkOutput("readyIdle", 32'(instrReady), 1);
    checkOutput("rfAAddr", 32'(rfAAddr), 32'(ra));
    @(posedge clk); #1;
    instrValid = 1'b0; instr = 16'($urandom);
    checkOutput("readyIssue", 32'(instrReady), 0);
    checkOutput("issueOp", 32'(aluOp), run ? 32'(op) : 15);
    if (run) begin
      checkOutput("issueA", 32'(aluA), 32'(va));
      checkOutput("issueB", 32'(aluB), 32'(expB));
    end
    @(posedge clk); #1;
    if (!run) begin
      checkOutput("skipWb", 32'(wbValid), 0);
      checkOutput("skipBr", 32'(brValid), 0);
      checkOutput("skipReady", 32'(instrReady), 1);
      checkOutput("skipFlagC", 32'(flagC), 32'(refC));
      checkOutput("skipFlagZ", 32'(flagZ), 32'(refZ));
    end else if (isBr) begin
      checkOutput("brValid", 32'(brValid), 1);
      checkOutput("brTaken", 32'(brTaken), 32'(res[0]));
      checkOutput("brNoWb", 32'(wbValid), 0);
    end else begin
      checkOutput("wbValid", 32'(wbValid), 1);
      checkOutput("wbAddr", 32'(wbAddr), 32'(dest));
      checkOutput("wbData", 32'(wbData), 32'(res));
      checkOutput("wbNoBr", 32'(brValid), 0);
      refRf[dest] = res;
      if (opc == 4'h1) begin refC = c; refZ = z; end
      if (opc == 4'h2) refZ = z;
    end
    if (run) begin
      @(posedge clk); #1;
      checkOutput("postReady", 32'(instrReady), 1);
      checkOutput("postWb", 32'(wbValid), 0);
      checkOutput("postFlagC", 32'(flagC), 32'(refC));
      checkOutput("postFlagZ", 32'(flagZ), 32'(refZ));
    end
  endtask

  initial begin
    int accepts[$];
    logic [3:0] ropc;
    legalOpc = '{4'h1, 4'h2, 4'h3, 4'h8, 4'h9, 4'hA};
    rstN = 1'b0; instrValid = 1'b0; instr = 16'd0;
    pokeEn = 1'b0; pokeAddr = 3'd0; pokeData = 16'd0;
    refC = 1'b0; refZ = 1'b0;
    #3;
    checkOutput("rstReady", 32'(instrReady), 1);
    checkOutput("rstWbValid", 32'(wbValid), 0);
    checkOutput("rstWbAddr", 32'(wbAddr), 0);
    checkOutput("rstWbData", 32'(wbData), 0);
    checkOutput("rstBrValid", 32'(brValid), 0);
    checkOutput("rstBrTaken", 32'(brTaken), 0);
    checkOutput("rstFlagC", 32'(flagC), 0);
    checkOutput("rstFlagZ", 32'(flagZ), 0);
    checkOutput("rstAluOp", 32'(aluOp), 15);
    checkOutput("rstAluA", 32'(aluA), 0);
    checkOutput("rstAluB", 32'(aluB), 0);
    @(posedge clk); @(negedge clk);
    rstN = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) pokeReg(i, 16'($urandom));

    $display("[TB] directed cases");
    pokeReg(1, 16'h0001); pokeReg(2, 16'h0002);
    applyStimulus({4'h1, 3'd1, 3'd2, 3'd3, 1'b0, 2'b00});
    pokeReg(1, 16'hFFFF); pokeReg(2, 16'h0001);
    applyStimulus({4'h1, 3'd1, 3'd2, 3'd3, 1'b0, 2'b00});
    checkOutput("carryOut", 32'(flagC), 1);
    checkOutput("zeroOut", 32'(flagZ), 1);
    pokeReg(1, 16'h0001); pokeReg(2, 16'h0002);
    applyStimulus({4'h1, 3'd1, 3'd2, 3'd4, 1'b0, 2'b00});
    applyStimulus({4'h1, 3'd1, 3'd2, 3'd5, 1'b0, 2'b10});
    applyStimulus({4'h2, 3'd1, 3'd2, 3'd5, 1'b0, 2'b01});
    pokeReg(1, 16'd5); pokeReg(2, 16'd9);
    applyStimulus({4'h9, 3'd1, 3'd2, 3'd0, 1'b0, 2'b00});
    applyStimulus({4'h3, 3'd0, 9'h1A5});
    applyStimulus({4'h7, 12'hABC});

    $display("[TB] random instructions");
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) < 8) ropc = legalOpc[$urandom_range(0, 5)];
      else ropc = 4'($urandom_range(0, 15));
      applyStimulus({ropc, 12'($urandom)});
    end
    for (int i = 0; i < 8; i++) checkOutput($sformatf("rf%0d", i), 32'(rf[i]), 32'(refRf[i]));

    $display("[TB] back-to-back");
    instrValid = 1'b1; instr = {4'h1, 3'd5, 3'd6, 3'd4, 1'b0, 2'b00};
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      if (instrReady) accepts.push_back(cyc);
    end
    instrValid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("b2bCount", 32'(accepts.size()), 5);
    for (int k = 1; k < accepts.size(); k++)
      checkOutput("b2bSpacing", 32'(accepts[k] - accepts[k-1]), 3);
    for (int i = 0; i < 8; i++) refRf[i] = rf[i];

    $display("[TB] reset during capture");
    pokeReg(1, 16'hFFFF); pokeReg(2, 16'h0001);
    applyStimulus({4'h1, 3'd1, 3'd2, 3'd7, 1'b0, 2'b00});
    instrValid = 1'b1; instr = {4'h1, 3'd1, 3'd1, 3'd3, 1'b0, 2'b00};
    @(posedge clk); #1;
    instrValid = 1'b0;
    @(posedge clk); #1;
    checkOutput("capStrobe", 32'(wbValid), 1);
    rstN = 1'b0;
    #1;
    checkOutput("rstMidWb", 32'(wbValid), 0);
    checkOutput("rstMidBr", 32'(brValid), 0);
    checkOutput("rstMidReady", 32'(instrReady), 1);
    checkOutput("rstMidFlagC", 32'(flagC), 0);
    checkOutput("rstMidFlagZ", 32'(flagZ), 0);
    @(posedge clk); @(negedge clk);
    rstN = 1'b1;
    @(posedge clk); #1;
    checkOutput("rstNoWrite", 32'(rf[3]), 32'(refRf[3]));
    refC = 1'b0; refZ = 1'b0;
    applyStimulus({4'h1, 3'd1, 3'd2, 3'd6, 1'b0, 2'b10});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
